abro_sequencer: RTL and testbench

Stimulus-side counterpart of the ABRO state machine: accepts queued drive commands and plays them onto the machine's A/B inputs as timed level windows. It watches the machine's O output during each window and reports, per command, whether O fired. It sits between a command source (bench or host) and ABRO_StateMachine, for directed and regression stimulus of the ABRO block.

---
 rtl/abro_pkg.sv | 15 +
 rtl/abro_cmd_fifo.sv | 56 +++++
 rtl/abro_sequencer.sv | 118 +++++++++++
 tb/tb_abro_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/abro_pkg.sv
// Shared definitions for the ABRO stimulus sequencer: FSM encoding and
// the layout of a queued drive command, {a, b, hold} from MSB to LSB.
package abro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2
  } abro_state_e;

  function automatic int cmd_width(input int hold_w);
    return hold_w + 2;
  endfunction

endpackage

// File: rtl/abro_cmd_fifo.sv
// Synchronous FIFO with first-word-fall-through read data. Pointers carry a
// wrap bit so full and empty are told apart by comparing the MSB.
module abro_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/abro_sequencer.sv
// Plays queued {a, b, hold} commands onto ABRO's A/B inputs as timed level
// windows and reports per command whether O fired during the window or SETTLE.
module abro_sequencer
  import abro_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_a,
  input  logic                    cmd_b,
  input  logic [HOLD_W-1:0]       cmd_hold,
  output logic                    A,
  output logic                    B,
  input  logic                    O,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    rsp_valid,
  output logic                    rsp_o
);

  localparam int CW = cmd_width(HOLD_W);

  abro_state_e       state_q, state_d;
  logic              a_q, a_d, b_q, b_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              seen_q, seen_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_o_q, rsp_o_d;

  logic          fifo_full, fifo_empty, pop;
  logic [CW-1:0] rdata;

  assign cmd_ready = ~fifo_full;
  assign pop       = (state_q == ST_IDLE) && !fifo_empty;

  abro_cmd_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid && cmd_ready),
    .wdata ({cmd_a, cmd_b, cmd_hold}),
    .pop   (pop),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    seen_d      = seen_q;
    rsp_valid_d = 1'b0;
    rsp_o_d     = rsp_o_q;
    case (state_q)
      ST_IDLE: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (!fifo_empty) begin
          a_d     = rdata[CW-1];
          b_d     = rdata[CW-2];
          cnt_d   = rdata[HOLD_W-1:0];
          seen_d  = 1'b0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        seen_d = seen_q | O;
        if (cnt_q == '0) begin
          a_d     = 1'b0;
          b_d     = 1'b0;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      ST_SETTLE: begin
        // O from ABRO lags A/B by a register, so the zero cycle still counts.
        rsp_valid_d = 1'b1;
        rsp_o_d     = seen_q | O;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      cnt_q       <= '0;
      seen_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_o_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_o_q     <= rsp_o_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_o     = rsp_o_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_abro_sequencer.sv
// Directed bench for abro_sequencer: a vector table of single commands, plus
// hand-written fill, closed-loop and mid-window reset sequences.
module tb_abro_sequencer;

  localparam int DEPTH  = 4;
  localparam int HOLD_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_a = 1'b0, cmd_b = 1'b0;
  logic [HOLD_W-1:0] cmd_hold = '0;
  logic              A, B, O;
  logic              busy;
  logic [2:0]        level;
  logic              rsp_valid, rsp_o;

  logic o_drv = 1'b0, o_sel = 1'b0;
  logic m_sa, m_sb, m_done, m_o;

  abro_sequencer #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_hold(cmd_hold), .A(A), .B(B), .O(O),
    .busy(busy), .level(level), .rsp_valid(rsp_valid), .rsp_o(rsp_o)
  );

  always #5 clk = ~clk;

  // Small ABRO model: O pulses one cycle after both A and B have been seen.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sa <= 1'b0; m_sb <= 1'b0; m_done <= 1'b0; m_o <= 1'b0;
    end else begin
      m_sa   <= m_sa | A;
      m_sb   <= m_sb | B;
      m_o    <= (m_sa | A) & (m_sb | B) & ~m_done;
      m_done <= m_done | ((m_sa | A) & (m_sb | B));
    end
  end

  assign O = o_sel ? m_o : o_drv;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Window monitor for the fill test: records {A,B} at each window start.
  logic       mon_en = 1'b0;
  logic       prev_ab = 1'b0;
  int         mon_rsp = 0;
  logic [1:0] mon_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if ((A | B) && !prev_ab) mon_q.push_back({A, B});
      prev_ab = A | B;
      if (rsp_valid) mon_rsp++;
    end
  end

  typedef struct {
    logic a;
    logic b;
    int   hold;
    logic model;
    int   k;        // O high for the cycle after accept edge + k; -1 = never
    logic exp_o;
    int   exp_a_cyc;
    int   exp_b_cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v, input int idx);
    int   a_cnt = 0, b_cnt = 0, rsp_cnt = 0, rsp_cyc = -1;
    logic rsp_o_s = 1'b0, a_first = 1'b0, b_first = 1'b0;
    @(negedge clk);
    o_sel = v.model; o_drv = 1'b0;
    cmd_valid = 1'b1; cmd_a = v.a; cmd_b = v.b; cmd_hold = HOLD_W'(v.hold);
    for (int cyc = 0; cyc <= v.hold + 6; cyc++) begin
      @(negedge clk);
      if (cyc == 0) cmd_valid = 1'b0;
      if (cyc == 1) begin a_first = A; b_first = B; end
      a_cnt += int'(A);
      b_cnt += int'(B);
      if (rsp_valid) begin rsp_cnt++; rsp_cyc = cyc; rsp_o_s = rsp_o; end
      o_drv = (cyc == v.k);
    end
    o_drv = 1'b0;
    chk($sformatf("v%0d A_first", idx), a_first, v.a);
    chk($sformatf("v%0d B_first", idx), b_first, v.b);
    chk($sformatf("v%0d A_cycles", idx), a_cnt, v.exp_a_cyc);
    chk($sformatf("v%0d B_cycles", idx), b_cnt, v.exp_b_cyc);
    chk($sformatf("v%0d rsp_count", idx), rsp_cnt, 1);
    chk($sformatf("v%0d rsp_latency", idx), rsp_cyc, v.hold + 3);
    chk($sformatf("v%0d rsp_o", idx), rsp_o_s, v.exp_o);
    chk($sformatf("v%0d busy_end", idx), busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] pat[6];
    int         acc, cyc, stall_n, stall_bad, w, bad, rsp_seen;
    int         acc_cyc[6];
    logic       rdy;
    logic [2:0] lvl;

    //          a     b     hold model k   exp_o  a_cyc b_cyc
    vecs[0] = '{1'b1, 1'b0, 1,   1'b1, -1, 1'b0,  2,    0};
    vecs[1] = '{1'b0, 1'b1, 1,   1'b1, -1, 1'b1,  0,    2};
    vecs[2] = '{1'b1, 1'b0, 2,   1'b0, -1, 1'b0,  3,    0};
    vecs[3] = '{1'b0, 1'b1, 0,   1'b0, 2,  1'b1,  0,    1};
    vecs[4] = '{1'b1, 1'b1, 15,  1'b0, 17, 1'b1,  16,   16};
    vecs[5] = '{1'b0, 1'b0, 3,   1'b0, -1, 1'b0,  0,    0};
    vecs[6] = '{1'b1, 1'b0, 4,   1'b0, 0,  1'b0,  5,    0};
    vecs[7] = '{1'b1, 1'b0, 4,   1'b0, 1,  1'b1,  5,    0};
    vecs[8] = '{1'b1, 1'b1, 2,   1'b0, 5,  1'b0,  3,    3};
    vecs[9] = '{1'b1, 1'b1, 2,   1'b0, 3,  1'b1,  3,    3};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst A", A, 1'b0);
    chk("rst B", B, 1'b0);
    chk("rst cmd_ready", cmd_ready, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst rsp_valid", rsp_valid, 1'b0);
    chk("rst level", level, 3'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst A", A, 1'b0);
    chk("post_rst busy", busy, 1'b0);
    chk("post_rst level", level, 3'd0);

    // Closed-loop vectors first so the ABRO model starts from reset.
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
    o_sel = 1'b0;

    // Fill: six back-to-back hold=15 commands into a 4-deep FIFO.
    pat = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01, 2'b11};
    acc = 0; cyc = 0; stall_n = 0; stall_bad = 0;
    @(negedge clk);
    mon_q.delete(); mon_rsp = 0; prev_ab = 1'b0; mon_en = 1'b1;
    while (acc < 6 && cyc < 100) begin
      if (cyc != 0) @(negedge clk);
      cmd_valid = 1'b1; {cmd_a, cmd_b} = pat[acc]; cmd_hold = 4'd15;
      rdy = cmd_ready; lvl = level;
      if (!rdy) begin
        stall_n++;
        if (lvl != 3'd4) stall_bad++;
      end
      @(posedge clk);
      if (rdy) begin acc_cyc[acc] = cyc; acc++; end
      cyc++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("fill accepted", acc, 6);
    chk("fill 5th accept cyc", acc_cyc[4], 4);
    chk("fill 6th accept cyc", acc_cyc[5], 20);
    chk("fill stall cycles", stall_n, 15);
    chk("fill stall level!=4", stall_bad, 0);
    w = 0;
    while (mon_rsp < 6 && w < 300) begin @(negedge clk); w++; end
    chk("fill rsp count", mon_rsp, 6);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("fill window count", mon_q.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("fill window %0d ab", i), (i < mon_q.size()) ? mon_q[i] : 2'bxx, pat[i]);
    chk("fill busy_end", busy, 1'b0);

    // Reset in the 2nd cycle of a hold=7 window with two commands queued.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 1'b1; cmd_b = 1'b1; cmd_hold = 4'd7;
    @(negedge clk);
    cmd_a = 1'b1; cmd_b = 1'b0; cmd_hold = 4'd3;
    @(negedge clk);
    cmd_a = 1'b0; cmd_b = 1'b1; cmd_hold = 4'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("midrst A before", A, 1'b1);
    chk("midrst level before", level, 3'd2);
    #1 reset = 1'b1;
    #1;
    chk("midrst A async", A, 1'b0);
    chk("midrst B async", B, 1'b0);
    chk("midrst level", level, 3'd0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    bad = 0; rsp_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
      if (A || B || busy) bad++;
    end
    chk("midrst dropped rsp", rsp_seen, 0);
    chk("midrst activity", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
